// File: rtl/gpio_in_cond_pkg.sv
// Shared types and constants for the GPIO input-conditioning stage.
package gpio_in_cond_pkg;

    // Edge selected by a pin's interrupt type bit.
    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } edge_type_e;

    localparam int DEB_CNT_W_DEF = 8;

    // True when the update event direction matches the selected edge.
    function automatic logic edge_match(input logic rise, input logic fall, input edge_type_e sel);
        logic hit;
        case (sel)
            EDGE_RISE: hit = rise;
            EDGE_FALL: hit = fall;
            default:   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/gpio_deb_cell.sv
// One pin: two-flop synchroniser, saturating debounce counter and the
// stable (debounced) state. o_rise/o_fall pulse combinationally in the
// cycle whose clock edge updates the stable flop.
module gpio_deb_cell
    import gpio_in_cond_pkg::*;
#(
    parameter int DEB_CNT_W = DEB_CNT_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pad,
    input  logic [DEB_CNT_W-1:0] i_deb_cfg,
    output logic                 o_stable,
    output logic                 o_rise,
    output logic                 o_fall
);

    localparam logic [DEB_CNT_W-1:0] CNT_ZERO = {DEB_CNT_W{1'b0}};
    localparam logic [DEB_CNT_W-1:0] CNT_ONE  = DEB_CNT_W'(1);
    localparam logic [DEB_CNT_W-1:0] CNT_MAX  = {DEB_CNT_W{1'b1}};

    logic                 r_s1;
    logic                 r_s2;
    logic                 r_stable;
    logic [DEB_CNT_W-1:0] r_cnt;
    logic [DEB_CNT_W-1:0] w_cnt_nxt;
    logic                 w_stable_nxt;
    logic                 w_upd;

    // Two-flop synchroniser, nothing between the stages.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_pad;
            r_s2 <= r_s1;
        end
    end

    // Debounce decision: restart on match, accept once the mismatch has
    // lasted past the threshold, otherwise keep counting (saturating).
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_stable_nxt = r_stable;
        w_upd        = 1'b0;
        if (r_s2 == r_stable) begin
            w_cnt_nxt = CNT_ZERO;
        end else if (r_cnt >= i_deb_cfg) begin
            w_stable_nxt = r_s2;
            w_cnt_nxt    = CNT_ZERO;
            w_upd        = 1'b1;
        end else if (r_cnt != CNT_MAX) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Counter and stable state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= CNT_ZERO;
            r_stable <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_stable <= w_stable_nxt;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_upd & r_s2;
    assign o_fall   = w_upd & ~r_s2;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-pin synchronise + debounce, qualified edge
// detection into sticky pending bits, and a combined interrupt request.
// Optional feature macro: GPIO_IN_COND_BOTH_EDGE_EN adds int_both_i, which
// makes a pin trigger on either edge regardless of int_type_i.
module gpio_in_cond
    import gpio_in_cond_pkg::*;
#(
    parameter int NO_OF_GPIO_PINS = 24,
    parameter int DEB_CNT_W       = DEB_CNT_W_DEF
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [NO_OF_GPIO_PINS-1:0] pad_i,
    input  logic [DEB_CNT_W-1:0]       deb_cfg_i,
    input  logic [NO_OF_GPIO_PINS-1:0] int_en_i,
    input  logic [NO_OF_GPIO_PINS-1:0] int_type_i,
    input  logic [NO_OF_GPIO_PINS-1:0] int_clr_i,
`ifdef GPIO_IN_COND_BOTH_EDGE_EN
    input  logic [NO_OF_GPIO_PINS-1:0] int_both_i,
`endif
    output logic [NO_OF_GPIO_PINS-1:0] gpio_o,
    output logic [NO_OF_GPIO_PINS-1:0] int_sts_o,
    output logic                       inta_o
);

    logic [NO_OF_GPIO_PINS-1:0] w_stable;
    logic [NO_OF_GPIO_PINS-1:0] w_rise;
    logic [NO_OF_GPIO_PINS-1:0] w_fall;
    logic [NO_OF_GPIO_PINS-1:0] w_both;
    logic [NO_OF_GPIO_PINS-1:0] w_set;
    logic [NO_OF_GPIO_PINS-1:0] r_sts;

    for (genvar g = 0; g < NO_OF_GPIO_PINS; g++) begin : g_pin
        gpio_deb_cell #(
            .DEB_CNT_W (DEB_CNT_W)
        ) u_cell (
            .i_clk     (wb_clk_i),
            .i_rst     (wb_rst_i),
            .i_pad     (pad_i[g]),
            .i_deb_cfg (deb_cfg_i),
            .o_stable  (w_stable[g]),
            .o_rise    (w_rise[g]),
            .o_fall    (w_fall[g])
        );
    end

`ifdef GPIO_IN_COND_BOTH_EDGE_EN
    assign w_both = int_both_i;
`else
    assign w_both = {NO_OF_GPIO_PINS{1'b0}};
`endif

    // Qualify each pin's update event against its enable and edge selection.
    always_comb begin
        w_set = {NO_OF_GPIO_PINS{1'b0}};
        for (int i = 0; i < NO_OF_GPIO_PINS; i++) begin
            if (w_both[i]) begin
                w_set[i] = int_en_i[i] & (w_rise[i] | w_fall[i]);
            end else begin
                w_set[i] = int_en_i[i] & edge_match(w_rise[i], w_fall[i], edge_type_e'(int_type_i[i]));
            end
        end
    end

    // Sticky pending bits; a set on the same edge as a clear wins.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_sts <= {NO_OF_GPIO_PINS{1'b0}};
        end else begin
            r_sts <= (r_sts & ~int_clr_i) | w_set;
        end
    end

    assign gpio_o    = w_stable;
    assign int_sts_o = r_sts;
    assign inta_o    = |(r_sts & int_en_i);

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed bench for gpio_in_cond with hand-computed expectations.
module tb_gpio_in_cond;

    localparam int N = 24;
    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] pad;
    logic [W-1:0] deb;
    logic [N-1:0] en;
    logic [N-1:0] typ;
    logic [N-1:0] clr;
`ifdef GPIO_IN_COND_BOTH_EDGE_EN
    logic [N-1:0] both;
`endif
    logic [N-1:0] gpio;
    logic [N-1:0] sts;
    logic         inta;

    int checks = 0;
    int errors = 0;

    gpio_in_cond #(.NO_OF_GPIO_PINS(N), .DEB_CNT_W(W)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .pad_i      (pad),
        .deb_cfg_i  (deb),
        .int_en_i   (en),
        .int_type_i (typ),
        .int_clr_i  (clr),
`ifdef GPIO_IN_COND_BOTH_EDGE_EN
        .int_both_i (both),
`endif
        .gpio_o     (gpio),
        .int_sts_o  (sts),
        .inta_o     (inta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        pad = {N{1'b1}};
        deb = 8'd0;
        en  = {N{1'b1}};
        typ = {N{1'b1}};
        clr = {N{1'b0}};
`ifdef GPIO_IN_COND_BOTH_EDGE_EN
        both = {N{1'b0}};
`endif
        // Outputs held at zero throughout reset even with pads high.
        tick(4);
        chk("rst_gpio", 32'(gpio), 32'h0);
        chk("rst_sts",  32'(sts),  32'h0);
        chk("rst_inta", 32'(inta), 32'h0);

        pad = {N{1'b0}};
        en  = {N{1'b0}};
        typ = {N{1'b0}};
        tick(3);
        rst = 1'b0;
        tick(4);
        chk("idle_gpio", 32'(gpio), 32'h0);

        // D = 0: pins 0,2,3,5,7 rise, visible exactly 3 edges later.
        pad = 24'h0000AD;
        tick(2);
        chk("d0_edge2", 32'(gpio), 32'h0);
        tick(1);
        chk("d0_edge3", 32'(gpio), 32'h0000AD);
        chk("d0_no_sts", 32'(sts), 32'h0);

        // D = 4: 4-cycle low glitch on pin 3 is filtered.
        deb = 8'd4;
        en[3] = 1'b1;
        typ[3] = 1'b1;
        pad[3] = 1'b0;
        tick(4);
        pad[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            chk("glitch_hold", 32'(gpio[3]), 32'h1);
        end

        // 5-cycle low passes: falls at edge 7, rise back at edge 12.
        pad[3] = 1'b0;
        tick(5);
        pad[3] = 1'b1;
        tick(1);
        chk("low5_edge6", 32'(gpio[3]), 32'h1);
        tick(1);
        chk("low5_edge7", 32'(gpio[3]), 32'h0);
        chk("low5_fall_not_rise", 32'(sts[3]), 32'h0);
        tick(4);
        chk("low5_edge11", 32'(gpio[3]), 32'h0);
        tick(1);
        chk("rise_edge12", 32'(gpio[3]), 32'h1);
        chk("rise_sts3", 32'(sts), 32'h000008);
        chk("rise_inta", 32'(inta), 32'h1);
        clr[3] = 1'b1;
        tick(1);
        clr[3] = 1'b0;
        chk("clr3_sts", 32'(sts), 32'h0);
        chk("clr3_inta", 32'(inta), 32'h0);

        // Falling edge qualification on pin 5, then clear.
        deb = 8'd0;
        en[5] = 1'b1;
        typ[5] = 1'b0;
        pad[5] = 1'b0;
        tick(2);
        chk("fall5_early", 32'(sts[5]), 32'h0);
        tick(1);
        chk("fall5_gpio", 32'(gpio), 32'h00008D);
        chk("fall5_sts",  32'(sts),  32'h000020);
        chk("fall5_inta", 32'(inta), 32'h1);
        clr[5] = 1'b1;
        tick(1);
        clr[5] = 1'b0;
        chk("clr5_sts",  32'(sts),  32'h0);
        chk("clr5_inta", 32'(inta), 32'h0);

        // Clear on the same edge as a qualified event on pin 2: set wins.
        en[2] = 1'b1;
        typ[2] = 1'b0;
        pad[2] = 1'b0;
        tick(2);
        clr[2] = 1'b1;
        tick(1);
        clr[2] = 1'b0;
        chk("setclr_sts", 32'(sts), 32'h000004);
        chk("setclr_gpio", 32'(gpio), 32'h000089);
        clr[2] = 1'b1;
        tick(1);
        clr[2] = 1'b0;
        chk("clr2_sts", 32'(sts), 32'h0);

        // Enable masking on pin 7.
        en[7] = 1'b1;
        typ[7] = 1'b0;
        pad[7] = 1'b0;
        tick(3);
        chk("mask_set", 32'(sts), 32'h000080);
        chk("mask_inta_on", 32'(inta), 32'h1);
        en[7] = 1'b0;
        #1;
        chk("mask_inta_off", 32'(inta), 32'h0);
        tick(2);
        chk("mask_sts_kept", 32'(sts), 32'h000080);
        chk("mask_inta_still_off", 32'(inta), 32'h0);
        en[7] = 1'b1;
        #1;
        chk("mask_inta_reen", 32'(inta), 32'h1);
        clr[7] = 1'b1;
        tick(1);
        clr[7] = 1'b0;
        chk("clr7_sts", 32'(sts), 32'h0);

        // D = 200 on pin 10, async reset mid-count.
        en  = 24'h000400;
        typ = 24'h000400;
        deb = 8'd200;
        pad[10] = 1'b1;
        tick(102);
        chk("long_midcount_gpio", 32'(gpio), 32'h000009);
        chk("long_midcount_sts",  32'(sts),  32'h0);
        rst = 1'b1;
        #1;
        chk("async_rst_gpio", 32'(gpio), 32'h0);
        chk("async_rst_sts",  32'(sts),  32'h0);
        chk("async_rst_inta", 32'(inta), 32'h0);
        tick(1);
        rst = 1'b0;
        tick(202);
        chk("post_rst_edge202", 32'(gpio), 32'h0);
        chk("post_rst_sts202",  32'(sts),  32'h0);
        tick(1);
        chk("post_rst_edge203", 32'(gpio), 32'h000409);
        chk("post_rst_sts203",  32'(sts),  32'h000400);
        chk("post_rst_inta",    32'(inta), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpio_in_cond.md
Name: gpio_in_cond

Overview:
- Input-conditioning stage directly upstream of the GPIO register block.
- Synchronises raw pad inputs, debounces each pin with a programmable filter length, and drives the cleaned bus into the register block's GPIO input.
- Detects qualified edges per pin, holds them in sticky pending bits, and raises one combined interrupt request.

Parameters:
- NO_OF_GPIO_PINS, 24, number of pins conditioned (1..32).
- DEB_CNT_W, 8, width of the per-pin debounce counter and of the threshold input.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- pad_i  in  NO_OF_GPIO_PINS  raw asynchronous pad inputs.
- deb_cfg_i  in  DEB_CNT_W  debounce threshold D, shared by all pins; quasi-static.
- int_en_i  in  NO_OF_GPIO_PINS  per-pin interrupt enable.
- int_type_i  in  NO_OF_GPIO_PINS  per-pin edge select: 1 = rising, 0 = falling.
- int_clr_i  in  NO_OF_GPIO_PINS  per-pin single-cycle clear strobe for pending bits.
- gpio_o  out  NO_OF_GPIO_PINS  debounced pin state; feeds the register block's GPIO input.
- int_sts_o  out  NO_OF_GPIO_PINS  sticky pending edge bits.
- inta_o  out  1  interrupt request.

Behaviour:
- Reset: sync stages, stable state, counters and pending bits all go to 0. Outputs are gpio_o = 0, int_sts_o = 0, inta_o = 0.
- Synchroniser: two flops per pin (s1, s2). No logic sits between s1 and s2.
- Debounce, per pin, with cnt of width DEB_CNT_W:
  - If s2 == stable, then cnt <= 0.
  - If s2 != stable and cnt >= D, then stable <= s2 and cnt <= 0. This cycle is the update event.
  - Otherwise (s2 != stable, cnt < D), cnt <= cnt + 1. cnt saturates at all-ones and never wraps.
- Latency: a clean pad transition appears on gpio_o exactly 3 + D clock edges after the first edge that samples it.
- D = 0 gives the minimum 3-edge latency with no filtering.
- A pulse shorter than D+1 cycles at s2 never reaches gpio_o.
- Lowering deb_cfg_i mid-count is covered by the >= compare: the update fires on the next mismatch edge.
- Edge qualification:
  - Rising event: update event with new stable = 1.
  - Falling event: update event with new stable = 0.
  - An event sets int_sts[i] on the same edge that updates stable[i], when int_en_i[i] = 1 and the direction matches int_type_i[i].
- Pending bits:
  - int_sts[i] stays set until int_clr_i[i] = 1 at a clock edge.
  - If a set and a clear hit the same edge, set wins; no event is lost.
  - Deasserting int_en_i does not clear pending bits.
- inta_o = |(int_sts & int_en_i). It is derived only from flops and the enable input, with no pad path.
- Reset mid-operation: asserting wb_rst_i clears everything asynchronously. After release, a pad held at 1 needs 3 + D edges to reach gpio_o, and generates a rising event if enabled.

Optional Feature:
- Macro: GPIO_IN_COND_BOTH_EDGE_EN.
- Defined:
  - Adds input port int_both_i [NO_OF_GPIO_PINS].
  - When int_both_i[i] = 1, either edge sets int_sts[i] and int_type_i[i] is ignored.
- Undefined:
  - The port does not exist.
  - Only the edge selected by int_type_i counts.

Decomposition:
- Package gpio_in_cond_pkg:
  - enum edge_type_e { EDGE_FALL = 0, EDGE_RISE = 1 }.
  - Constant DEB_CNT_W_DEF = 8.
- Sub-module gpio_deb_cell: one pin's synchroniser, counter, stable flop and event output, generated NO_OF_GPIO_PINS times.
- The top level holds the pending register, the edge qualification and the inta_o reduction.

Test Plan:
- Reset and default debounce: D = 0, pad[0] goes 0→1 → gpio_o[0] = 1 exactly 3 edges later; all outputs 0 during reset.
- Debounce filtering: D = 4, pad[3] has a 1→0 glitch 4 cycles wide → gpio_o[3] unchanged. A 5-cycle low → gpio_o[3] = 0 at edge 7, int_sts[3] = 0 with int_type = 1.
- Edge qualification and clear: int_en[5] = 1, int_type[5] = 0, pad[5] falls → int_sts[5] = 1, inta_o = 1. Pulse int_clr[5] → both 0 next cycle.
- Simultaneous set and clear: time int_clr[2] on the same edge as a qualified event on pin 2 → int_sts[2] stays 1.
- Enable masking: int_sts[7] = 1, then int_en[7] 1→0 → inta_o = 0 and int_sts[7] stays 1. Re-enable → inta_o = 1.
- Async reset mid-count: D = 200, reset at count 100 → gpio_o = 0 and cnt restarts. Pad held high → gpio_o = 1 at edge 203 after release.
